// File: rtl/btb_pkg.sv
// Shared defaults, PC geometry and counter helper for the branch target buffer.
package btb_pkg;

   localparam int DEFAULT_DATA_W  = 64;
   localparam int DEFAULT_ENTRIES = 16;
   localparam int DEFAULT_CTR_W   = 2;

   localparam int PC_ALIGN = 2;
   localparam int PC_INCR  = 4;

   typedef enum logic [1:0] {
      UPD_NONE  = 2'd0,
      UPD_TRAIN = 2'd1,
      UPD_ALLOC = 2'd2
   } upd_action_e;

   // Counter travels in a 32-bit container so one function serves any CTR_W below 32.
   function automatic logic [31:0] sat_ctr_next(input logic [31:0] ctr,
                                                input logic        taken,
                                                input int unsigned ctr_w);
      logic [31:0] ctr_max;
      ctr_max = (32'd1 << ctr_w) - 32'd1;
      if (taken) begin
         return (ctr >= ctr_max) ? ctr_max : ctr + 32'd1;
      end
      return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
   endfunction

endpackage

// File: rtl/btb_stats.sv
// Update and misprediction counters for the branch target buffer (BTB_STATS_EN builds only).
module btb_stats (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        upd_accept,
   input  logic        upd_mispredict,
   output logic [31:0] stat_updates,
   output logic [31:0] stat_mispredicts
);

   // Both counters wrap modulo 2^32 by plain overflow.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stat_updates     <= 32'd0;
         stat_mispredicts <= 32'd0;
      end else if (upd_accept) begin
         stat_updates <= stat_updates + 32'd1;
         if (upd_mispredict) begin
            stat_mispredicts <= stat_mispredicts + 32'd1;
         end
      end
   end

endmodule

// File: rtl/branch_target_buffer.sv
// Tag-checked branch target buffer with saturating direction counters.
// Optional statistics counters are built when BTB_STATS_EN is defined.
module branch_target_buffer
   import btb_pkg::*;
#(
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int ENTRIES = DEFAULT_ENTRIES,
   parameter int CTR_W   = DEFAULT_CTR_W
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              en,
   input  logic [DATA_W-1:0] lookup_pc,
   output logic              pred_taken,
   output logic [DATA_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic [DATA_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [DATA_W-1:0] upd_target,
   input  logic              upd_pred_taken
`ifdef BTB_STATS_EN
   ,
   output logic [31:0]       stat_updates,
   output logic [31:0]       stat_mispredicts
`endif
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = DATA_W - IDX_W - PC_ALIGN;

   localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1) << (CTR_W - 1);
   localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_W'(1);

   logic              valid_q  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [DATA_W-1:0] target_q [ENTRIES];
   logic [CTR_W-1:0]  ctr_q    [ENTRIES];

   logic [IDX_W-1:0]  lk_idx;
   logic [TAG_W-1:0]  lk_tag;
   logic              lk_hit;

   logic [IDX_W-1:0]  upd_idx;
   logic [TAG_W-1:0]  upd_tag;
   logic              upd_hit;
   logic              upd_accept;
   logic [31:0]       ctr_next_full;
   logic [CTR_W-1:0]  ctr_next;
   upd_action_e       upd_action;

   logic              unused_bits;

   assign lk_idx = lookup_pc[IDX_W+PC_ALIGN-1:PC_ALIGN];
   assign lk_tag = lookup_pc[DATA_W-1:IDX_W+PC_ALIGN];
   assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

   // Reads see only registered state, so a same-cycle update to this index is not forwarded.
   assign pred_taken  = lk_hit && ctr_q[lk_idx][CTR_W-1];
   assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + DATA_W'(PC_INCR);

   assign upd_idx    = upd_pc[IDX_W+PC_ALIGN-1:PC_ALIGN];
   assign upd_tag    = upd_pc[DATA_W-1:IDX_W+PC_ALIGN];
   assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign upd_accept = upd_valid && en;

   assign ctr_next_full = sat_ctr_next(32'(ctr_q[upd_idx]), upd_taken, CTR_W);
   assign ctr_next      = ctr_next_full[CTR_W-1:0];

   always_comb begin
      upd_action = UPD_NONE;
      if (upd_accept) begin
         if (upd_hit) begin
            upd_action = UPD_TRAIN;
         end else if (upd_taken) begin
            upd_action = UPD_ALLOC;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WEAK_NT;
         end
      end else begin
         case (upd_action)
            UPD_TRAIN: begin
               ctr_q[upd_idx] <= ctr_next;
               if (upd_taken) begin
                  target_q[upd_idx] <= upd_target;
               end
            end
            // A taken miss evicts whatever shared the index and starts weakly taken.
            UPD_ALLOC: begin
               valid_q[upd_idx]  <= 1'b1;
               tag_q[upd_idx]    <= upd_tag;
               target_q[upd_idx] <= upd_target;
               ctr_q[upd_idx]    <= CTR_WEAK_T;
            end
            default: ;
         endcase
      end
   end

`ifdef BTB_STATS_EN
   btb_stats u_stats (
      .clk              (clk),
      .arst_n           (arst_n),
      .upd_accept       (upd_accept),
      .upd_mispredict   (upd_pred_taken != upd_taken),
      .stat_updates     (stat_updates),
      .stat_mispredicts (stat_mispredicts)
   );

   assign unused_bits = ^{lookup_pc[PC_ALIGN-1:0], upd_pc[PC_ALIGN-1:0], ctr_next_full[31:CTR_W]};
`else
   assign unused_bits = ^{lookup_pc[PC_ALIGN-1:0], upd_pc[PC_ALIGN-1:0], ctr_next_full[31:CTR_W],
                          upd_pred_taken};
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (ENTRIES=16, CTR_W=2, DATA_W=64).
// Statistics checks are included when BTB_STATS_EN is defined.
`timescale 1ns/1ps
module tb_branch_target_buffer;

   logic        clk;
   logic        arst_n;
   logic        en;
   logic [63:0] lookup_pc;
   logic        pred_taken;
   logic [63:0] pred_target;
   logic        upd_valid;
   logic [63:0] upd_pc;
   logic        upd_taken;
   logic [63:0] upd_target;
   logic        upd_pred_taken;
`ifdef BTB_STATS_EN
   logic [31:0] stat_updates;
   logic [31:0] stat_mispredicts;
`endif

   int check_count = 0;
   int fail_count  = 0;

   branch_target_buffer #(
      .DATA_W  (64),
      .ENTRIES (16),
      .CTR_W   (2)
   ) dut (
      .clk              (clk),
      .arst_n           (arst_n),
      .en               (en),
      .lookup_pc        (lookup_pc),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_pred_taken   (upd_pred_taken)
`ifdef BTB_STATS_EN
      ,
      .stat_updates     (stat_updates),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      check_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One update presented for exactly one rising edge, then withdrawn.
   task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic t,
                                input logic [63:0] tgt, input logic pt, input logic e);
      @(negedge clk);
      upd_valid      = v;
      upd_pc         = pc;
      upd_taken      = t;
      upd_target     = tgt;
      upd_pred_taken = pt;
      en             = e;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      en        = 1'b1;
   endtask

   task automatic lookupCheck(input string tag, input logic [63:0] pc,
                              input logic exp_taken, input logic [63:0] exp_target);
      lookup_pc = pc;
      #1;
      checkOutput({tag, ".taken"}, {63'd0, pred_taken}, {63'd0, exp_taken});
      checkOutput({tag, ".target"}, pred_target, exp_target);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      arst_n         = 1'b0;
      en             = 1'b1;
      lookup_pc      = 64'h100;
      upd_valid      = 1'b0;
      upd_pc         = '0;
      upd_taken      = 1'b0;
      upd_target     = '0;
      upd_pred_taken = 1'b0;

      #12;
      lookupCheck("reset_100", 64'h100, 1'b0, 64'h104);
      lookupCheck("reset_140", 64'h140, 1'b0, 64'h144);
      @(negedge clk);
      arst_n = 1'b1;
      @(posedge clk);
      #1;

      // Allocation: pre-edge contents during the training cycle, new entry afterwards.
      @(negedge clk);
      upd_valid  = 1'b1;
      upd_pc     = 64'h100;
      upd_taken  = 1'b1;
      upd_target = 64'h80;
      lookupCheck("alloc_same_cycle", 64'h100, 1'b0, 64'h104);
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      lookupCheck("alloc_next_cycle", 64'h100, 1'b1, 64'h80);

      // Hysteresis starting from weakly taken.
      applyStimulus(1'b1, 64'h100, 1'b0, 64'h0,  1'b1, 1'b1);
      lookupCheck("hyst_nt1_ctr01", 64'h100, 1'b0, 64'h104);
      applyStimulus(1'b1, 64'h100, 1'b1, 64'h80, 1'b0, 1'b1);
      lookupCheck("hyst_t1_ctr10", 64'h100, 1'b1, 64'h80);
      applyStimulus(1'b1, 64'h100, 1'b1, 64'h80, 1'b1, 1'b1);
      lookupCheck("hyst_t2_ctr11", 64'h100, 1'b1, 64'h80);
      applyStimulus(1'b1, 64'h100, 1'b1, 64'h80, 1'b1, 1'b1);
      lookupCheck("hyst_sat_hi", 64'h100, 1'b1, 64'h80);
      applyStimulus(1'b1, 64'h100, 1'b0, 64'h0,  1'b1, 1'b1);
      lookupCheck("hyst_nt_ctr10", 64'h100, 1'b1, 64'h80);
      applyStimulus(1'b1, 64'h100, 1'b0, 64'h0,  1'b1, 1'b1);
      lookupCheck("hyst_nt_ctr01", 64'h100, 1'b0, 64'h104);
      applyStimulus(1'b1, 64'h100, 1'b0, 64'h0,  1'b0, 1'b1);
      applyStimulus(1'b1, 64'h100, 1'b0, 64'h0,  1'b0, 1'b1);
      lookupCheck("hyst_sat_lo", 64'h100, 1'b0, 64'h104);
      applyStimulus(1'b1, 64'h100, 1'b1, 64'h80, 1'b0, 1'b1);
      lookupCheck("hyst_from00_ctr01", 64'h100, 1'b0, 64'h104);
      applyStimulus(1'b1, 64'h100, 1'b1, 64'h80, 1'b0, 1'b1);
      lookupCheck("hyst_back_ctr10", 64'h100, 1'b1, 64'h80);

      // Taken hit rewrites the target; not-taken hit leaves it alone.
      applyStimulus(1'b1, 64'h100, 1'b1, 64'h88, 1'b1, 1'b1);
      lookupCheck("target_rewrite", 64'h100, 1'b1, 64'h88);
      applyStimulus(1'b1, 64'h100, 1'b0, 64'h999, 1'b1, 1'b1);
      lookupCheck("target_kept_nt", 64'h100, 1'b1, 64'h88);

      // Aliasing on index 0.
      lookupCheck("alias_140_miss", 64'h140, 1'b0, 64'h144);
      applyStimulus(1'b1, 64'h140, 1'b1, 64'h200, 1'b0, 1'b1);
      lookupCheck("alias_140_hit", 64'h140, 1'b1, 64'h200);
      lookupCheck("alias_100_evicted", 64'h100, 1'b0, 64'h104);

      // Gating: not-taken miss and en=0 must not allocate.
      applyStimulus(1'b1, 64'h180, 1'b0, 64'h500, 1'b0, 1'b1);
      lookupCheck("nt_miss_no_alloc", 64'h180, 1'b0, 64'h184);
      lookupCheck("nt_miss_keeps_140", 64'h140, 1'b1, 64'h200);
      applyStimulus(1'b1, 64'h180, 1'b1, 64'h500, 1'b0, 1'b0);
      lookupCheck("en0_no_alloc", 64'h180, 1'b0, 64'h184);
      applyStimulus(1'b1, 64'h140, 1'b0, 64'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 64'h140, 1'b0, 64'h0, 1'b1, 1'b0);
      lookupCheck("en0_no_train", 64'h140, 1'b1, 64'h200);

      // Second index, with pc[1:0] ignored on lookup.
      applyStimulus(1'b1, 64'h104, 1'b1, 64'h300, 1'b0, 1'b1);
      lookupCheck("idx1_hit", 64'h104, 1'b1, 64'h300);
      lookupCheck("idx1_low_bits", 64'h106, 1'b1, 64'h300);

      // Reset asserted while an update is being presented.
      @(negedge clk);
      upd_valid  = 1'b1;
      upd_pc     = 64'h108;
      upd_taken  = 1'b1;
      upd_target = 64'h400;
      #2;
      arst_n = 1'b0;
      lookupCheck("midrst_140", 64'h140, 1'b0, 64'h144);
      @(posedge clk);
      #1;
      lookupCheck("midrst_104", 64'h104, 1'b0, 64'h108);
      lookupCheck("midrst_108", 64'h108, 1'b0, 64'h10c);
      upd_valid = 1'b0;
      @(negedge clk);
      arst_n = 1'b1;
      @(posedge clk);
      #1;
      lookupCheck("postrst_140", 64'h140, 1'b0, 64'h144);
      lookupCheck("postrst_108", 64'h108, 1'b0, 64'h10c);

`ifdef BTB_STATS_EN
      checkOutput("stat_upd_reset", {32'd0, stat_updates}, 64'd0);
      checkOutput("stat_mis_reset", {32'd0, stat_mispredicts}, 64'd0);
      applyStimulus(1'b1, 64'h10, 1'b1, 64'h40, 1'b1, 1'b1);
      applyStimulus(1'b1, 64'h14, 1'b0, 64'h0,  1'b0, 1'b1);
      applyStimulus(1'b1, 64'h18, 1'b1, 64'h60, 1'b0, 1'b1);
      applyStimulus(1'b1, 64'h1c, 1'b1, 64'h70, 1'b0, 1'b0);
      checkOutput("stat_updates", {32'd0, stat_updates}, 64'd3);
      checkOutput("stat_mispredicts", {32'd0, stat_mispredicts}, 64'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end

endmodule
